// File: rtl/switch_conditioner.sv
// Four-switch synchronizer and debouncer with edge pulses and a single-entry event register.
// Latency: a level change shows on sw_stable DEBOUNCE_CNT+2 edges after it is sampled. An unacked event holds and later changes raise evt_overrun.
module switch_conditioner #(
    parameter int DEBOUNCE_CNT = 16,
    parameter int CNT_W        = 8
) (
    input  logic       clock_in,
    input  logic       reset,
    input  logic [3:0] switch,
    output logic [3:0] sw_stable,
    output logic [3:0] sw_rise,
    output logic [3:0] sw_fall,
    output logic       evt_valid,
    output logic [3:0] evt_data,
    input  logic       evt_ack,
    output logic       evt_overrun
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CNT - 1);

    logic [3:0]       sync1;
    logic [3:0]       sync2;
    logic [CNT_W-1:0] cnt     [4];
    logic [CNT_W-1:0] cnt_nxt [4];
    logic [3:0]       stable_nxt;
    logic             upd;

    // Any return of sync2 to the stable level restarts that bit's count.
    always_comb begin
        stable_nxt = sw_stable;
        for (int i = 0; i < 4; i++) begin
            cnt_nxt[i] = '0;
            if (sync2[i] != sw_stable[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    stable_nxt[i] = sync2[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign upd = (stable_nxt != sw_stable);

    always_ff @(posedge clock_in) begin
        if (reset) begin
            sync1       <= '0;
            sync2       <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
            sw_stable   <= '0;
            sw_rise     <= '0;
            sw_fall     <= '0;
            evt_valid   <= 1'b0;
            evt_data    <= '0;
            evt_overrun <= 1'b0;
        end else begin
            sync1     <= switch;
            sync2     <= sync1;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
            sw_stable <= stable_nxt;
            sw_rise   <= stable_nxt & ~sw_stable;
            sw_fall   <= ~stable_nxt & sw_stable;
            // An ack that coincides with a new update hands over straight to the new snapshot.
            if (evt_valid) begin
                if (evt_ack && upd) begin
                    evt_data <= stable_nxt;
                end else if (evt_ack) begin
                    evt_valid   <= 1'b0;
                    evt_overrun <= 1'b0;
                end else if (upd) begin
                    evt_overrun <= 1'b1;
                end
            end else if (upd) begin
                evt_valid <= 1'b1;
                evt_data  <= stable_nxt;
            end
        end
    end
endmodule

// File: tb/tb_switch_conditioner.sv
// Directed scenarios followed by random switching, checked against a window-based reference model.
module tb_switch_conditioner;
    localparam int D = 4;

    logic       clock_in = 1'b0;
    logic       reset;
    logic       evt_ack;
    logic [3:0] switch;
    logic [3:0] sw_stable;
    logic [3:0] sw_rise;
    logic [3:0] sw_fall;
    logic [3:0] evt_data;
    logic       evt_valid;
    logic       evt_overrun;

    int checks = 0;
    int errors = 0;

    // Reference state: two-stage input delay, then the last D synchronized samples (newest at [0]).
    logic [3:0] m_s1, m_s2, m_stable, m_rise, m_fall, m_data;
    logic       m_valid, m_ovr;
    logic [3:0] hist [D];

    always #5 clock_in = ~clock_in;

    switch_conditioner #(.DEBOUNCE_CNT(D), .CNT_W(8)) dut (
        .clock_in    (clock_in),
        .reset       (reset),
        .switch      (switch),
        .sw_stable   (sw_stable),
        .sw_rise     (sw_rise),
        .sw_fall     (sw_fall),
        .evt_valid   (evt_valid),
        .evt_data    (evt_data),
        .evt_ack     (evt_ack),
        .evt_overrun (evt_overrun)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_s1 = '0; m_s2 = '0; m_stable = '0; m_rise = '0; m_fall = '0;
        m_data = '0; m_valid = 1'b0; m_ovr = 1'b0;
        for (int i = 0; i < D; i++) hist[i] = '0;
    endtask

    // One clock: drive inputs, advance the model at the edge, compare all outputs just after it.
    task automatic step(input logic [3:0] s, input logic a, input logic r);
        logic [3:0] nxt;
        logic       upd;
        logic       run;
        switch  = s;
        evt_ack = a;
        reset   = r;
        @(posedge clock_in);
        if (r) begin
            model_clear();
        end else begin
            for (int i = D - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = m_s2;
            m_s2 = m_s1;
            m_s1 = s;
            // A bit flips once its last D synchronized samples all disagree with the stable level.
            nxt = m_stable;
            for (int b = 0; b < 4; b++) begin
                run = 1'b1;
                for (int i = 0; i < D; i++) begin
                    if (hist[i][b] == m_stable[b]) run = 1'b0;
                end
                if (run) nxt[b] = ~m_stable[b];
            end
            upd    = (nxt != m_stable);
            m_rise = nxt & ~m_stable;
            m_fall = ~nxt & m_stable;
            if (m_valid) begin
                if (a && upd) m_data = nxt;
                else if (a) begin
                    m_valid = 1'b0;
                    m_ovr   = 1'b0;
                end else if (upd) m_ovr = 1'b1;
            end else if (upd) begin
                m_valid = 1'b1;
                m_data  = nxt;
            end
            m_stable = nxt;
        end
        #1;
        chk("model_stable",  sw_stable, m_stable);
        chk("model_rise",    sw_rise,   m_rise);
        chk("model_fall",    sw_fall,   m_fall);
        chk("model_valid",   {3'b000, evt_valid},   {3'b000, m_valid});
        chk("model_data",    evt_data,  m_data);
        chk("model_overrun", {3'b000, evt_overrun}, {3'b000, m_ovr});
    endtask

    initial begin
        logic [3:0] cur;
        logic [3:0] s;
        switch  = '0;
        evt_ack = 1'b0;
        reset   = 1'b1;
        model_clear();

        step(4'b0000, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b1);
        chk("reset_stable", sw_stable, 4'b0000);
        chk("reset_valid",  {3'b000, evt_valid}, 4'b0000);

        // Clean press of switch[0]
        repeat (5) step(4'b0001, 1'b0, 1'b0);
        chk("press_not_yet", sw_stable, 4'b0000);
        step(4'b0001, 1'b0, 1'b0);
        chk("press_stable", sw_stable, 4'b0001);
        chk("press_rise",   sw_rise,   4'b0001);
        chk("press_valid",  {3'b000, evt_valid}, 4'b0001);
        chk("press_data",   evt_data,  4'b0001);
        step(4'b0001, 1'b0, 1'b0);
        chk("press_rise_once", sw_rise, 4'b0000);

        // Handshake, then a second ack with nothing pending
        step(4'b0001, 1'b1, 1'b0);
        chk("ack_clears", {3'b000, evt_valid}, 4'b0000);
        step(4'b0001, 1'b1, 1'b0);
        chk("idle_ack_valid",  {3'b000, evt_valid}, 4'b0000);
        chk("idle_ack_stable", sw_stable, 4'b0001);

        // Press switch[1] to leave event 0011 pending
        repeat (6) step(4'b0011, 1'b0, 1'b0);
        chk("second_press_data", evt_data, 4'b0011);

        // switch[2] bounces with period 4, ending low
        for (int i = 0; i < 20; i++) step({1'b0, ((i / 2) % 2 == 0), 2'b11}, 1'b0, 1'b0);
        chk("bounce_no_change", sw_stable, 4'b0011);
        repeat (5) step(4'b0111, 1'b0, 1'b0);
        chk("bounce_not_yet", sw_stable, 4'b0011);
        // Ack lands on the same edge as the 0011 -> 0111 update
        step(4'b0111, 1'b1, 1'b0);
        chk("coincide_stable",  sw_stable, 4'b0111);
        chk("coincide_valid",   {3'b000, evt_valid}, 4'b0001);
        chk("coincide_data",    evt_data, 4'b0111);
        chk("coincide_overrun", {3'b000, evt_overrun}, 4'b0000);
        step(4'b0111, 1'b1, 1'b0);

        // Reset three edges into a debounce of switch[3]
        repeat (3) step(4'b1111, 1'b0, 1'b0);
        step(4'b1111, 1'b0, 1'b1);
        step(4'b1111, 1'b0, 1'b1);
        chk("midreset_stable", sw_stable, 4'b0000);
        chk("midreset_rise",   sw_rise,   4'b0000);
        chk("midreset_valid",  {3'b000, evt_valid}, 4'b0000);
        repeat (5) step(4'b1111, 1'b0, 1'b0);
        chk("release_not_yet", sw_stable, 4'b0000);
        step(4'b1111, 1'b0, 1'b0);
        chk("release_stable", sw_stable, 4'b1111);
        chk("release_rise",   sw_rise,   4'b1111);
        chk("release_data",   evt_data,  4'b1111);

        // Overrun: event 0001 pending, then switch[1] press without ack
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b1);
        repeat (6) step(4'b0001, 1'b0, 1'b0);
        repeat (6) step(4'b0011, 1'b0, 1'b0);
        chk("overrun_stable", sw_stable, 4'b0011);
        chk("overrun_data",   evt_data,  4'b0001);
        chk("overrun_flag",   {3'b000, evt_overrun}, 4'b0001);
        step(4'b0011, 1'b1, 1'b0);
        chk("overrun_cleared", {3'b000, evt_overrun}, 4'b0000);
        chk("overrun_valid",   {3'b000, evt_valid},   4'b0000);

        // Random switching with short glitches, random acks and rare resets
        cur = 4'b0011;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 4) == 0) cur[$urandom_range(0, 3)] = ~cur[$urandom_range(0, 3)];
            s = cur;
            if ($urandom_range(0, 9) == 0) s = cur ^ 4'($urandom_range(1, 15));
            step(s, ($urandom_range(0, 3) == 0), ($urandom_range(0, 399) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
